// File: rtl/div_pkg.sv
// Shared constants and types for the sequential restoring divider.
package div_pkg;

    localparam int unsigned DEFAULT_WIDTH = 32;
    localparam int unsigned DEFAULT_CNT_W = 6;

    // Quotient reported when the divisor is zero
    localparam logic [DEFAULT_WIDTH-1:0] DZ_QUOTIENT = '1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } div_state_t;

endpackage

// File: rtl/div_sub_stage.sv
// One restoring-division step: trial subtract of the divisor from the shifted remainder.
module div_sub_stage #(
    parameter int unsigned WIDTH = 32
) (
    input  logic [WIDTH-1:0] r_shifted,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] r_next_c,
    output logic             q_bit_c
);

    logic [WIDTH:0] trial;

    // Borrow-out of the WIDTH+1-bit subtract decides whether the remainder is restored
    always_comb begin
        trial    = {1'b0, r_shifted} - {1'b0, d};
        q_bit_c  = ~trial[WIDTH];
        r_next_c = trial[WIDTH] ? r_shifted : trial[WIDTH-1:0];
    end

endmodule

// File: rtl/seq_restoring_divider.sv
// Multi-cycle unsigned restoring divider with valid/ready request and response handshakes.
module seq_restoring_divider
    import div_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH,
    parameter int unsigned CNT_W = DEFAULT_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    div_state_t       state;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] divisor_q;
    logic [WIDTH-1:0] r_shifted;
    logic [WIDTH-1:0] r_next_c;
    logic             q_bit_c;

    // quotient/remainder double as the Q/R working registers; {R,Q} shifts left each step
    assign r_shifted = {remainder[WIDTH-2:0], quotient[WIDTH-1]};

    div_sub_stage #(
        .WIDTH (WIDTH)
    ) u_sub_stage (
        .r_shifted (r_shifted),
        .d         (divisor_q),
        .r_next_c  (r_next_c),
        .q_bit_c   (q_bit_c)
    );

    // Control FSM, iteration counter, working registers and handshake outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            cnt         <= '0;
            divisor_q   <= '0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
            in_ready    <= 1'b1;
            res_valid   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        state     <= S_CALC;
                        in_ready  <= 1'b0;
                        divisor_q <= divisor;
                        if (divisor == '0) begin
                            // Divide-by-zero result is loaded now and held through one CALC cycle
                            quotient    <= '1;
                            remainder   <= dividend;
                            div_by_zero <= 1'b1;
                            cnt         <= CNT_W'(1);
                        end else begin
                            quotient    <= dividend;
                            remainder   <= '0;
                            div_by_zero <= 1'b0;
                            cnt         <= CNT_W'(WIDTH);
                        end
                    end
                end

                S_CALC: begin
                    if (!div_by_zero) begin
                        quotient  <= {quotient[WIDTH-2:0], q_bit_c};
                        remainder <= r_next_c;
                    end
                    cnt <= cnt - CNT_W'(1);
                    if (cnt == CNT_W'(1)) begin
                        state     <= S_DONE;
                        res_valid <= 1'b1;
                    end
                end

                S_DONE: begin
                    if (res_ready) begin
                        state     <= S_IDLE;
                        res_valid <= 1'b0;
                        in_ready  <= 1'b1;
                    end
                end

                default: begin
                    state     <= S_IDLE;
                    res_valid <= 1'b0;
                    in_ready  <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_restoring_divider.sv
// Directed bench for seq_restoring_divider at WIDTH=32.
module tb_seq_restoring_divider;

    localparam int unsigned W = 32;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         res_ready = 1'b0;
    logic [W-1:0] dividend = '0;
    logic [W-1:0] divisor = '0;
    logic         in_ready;
    logic         res_valid;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         div_by_zero;

    int checks = 0;
    int failures = 0;

    seq_restoring_divider #(
        .WIDTH (32),
        .CNT_W (6)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .dividend    (dividend),
        .divisor     (divisor),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Advance one edge, then sample 1 time unit later and check for X/Z
    task automatic tick();
        @(posedge clk);
        #1;
        chk("outputs_known",
            64'($isunknown({in_ready, res_valid, quotient, remainder, div_by_zero})), 64'd0);
    endtask

    // Present a request while idle and take it on the next edge
    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b);
        chk("in_ready_idle", 64'(in_ready), 64'd1);
        in_valid = 1'b1;
        dividend = a;
        divisor  = b;
        tick();
        in_valid = 1'b0;
        dividend = $urandom;
        divisor  = $urandom;
        chk("in_ready_busy", 64'(in_ready), 64'd0);
    endtask

    task automatic await_result(input string tag, input int exp_lat);
        int lat = 0;
        while (!res_valid && lat < 200) begin
            tick();
            lat++;
        end
        chk({tag, "_latency"}, 64'(lat), 64'(exp_lat));
    endtask

    task automatic check_result(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                                input logic [W-1:0] q, input logic [W-1:0] r, input logic dz);
        logic [63:0] recon;
        chk({tag, "_res_valid"}, 64'(res_valid), 64'd1);
        chk({tag, "_in_ready"}, 64'(in_ready), 64'd0);
        chk({tag, "_quotient"}, 64'(quotient), 64'(q));
        chk({tag, "_remainder"}, 64'(remainder), 64'(r));
        chk({tag, "_div_by_zero"}, 64'(div_by_zero), 64'(dz));
        if (b != '0) begin
            recon = 64'(quotient) * 64'(b) + 64'(remainder);
            chk({tag, "_identity"}, recon, 64'(a));
            chk({tag, "_rem_lt_div"}, 64'(remainder < b), 64'd1);
        end
    endtask

    task automatic release_result(input string tag);
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        chk({tag, "_res_valid_drop"}, 64'(res_valid), 64'd0);
        chk({tag, "_in_ready_back"}, 64'(in_ready), 64'd1);
    endtask

    task automatic run(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W-1:0] q, input logic [W-1:0] r, input logic dz,
                       input int lat);
        send(a, b);
        await_result(tag, lat);
        check_result(tag, a, b, q, r, dz);
        release_result(tag);
    endtask

    initial begin
        // Reset state
        rst_n = 1'b0;
        tick();
        tick();
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_res_valid", 64'(res_valid), 64'd0);
        chk("rst_quotient", 64'(quotient), 64'd0);
        chk("rst_remainder", 64'(remainder), 64'd0);
        chk("rst_div_by_zero", 64'(div_by_zero), 64'd0);
        rst_n = 1'b1;
        tick();

        run("c1_100_7", 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 32);
        run("c2_max_1", 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'd0, 1'b0, 32);
        run("c3_3_10", 32'd3, 32'd10, 32'd0, 32'd3, 1'b0, 32);
        run("c4_max_max", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0, 32);
        run("c5_div0", 32'd5, 32'd0, 32'hFFFF_FFFF, 32'd5, 1'b1, 1);
        run("c5b_top_bit", 32'hFFFF_FFFF, 32'h8000_0001, 32'd1, 32'h7FFF_FFFE, 1'b0, 32);

        // Backpressure: result must hold while a competing request waits
        send(32'd1000, 32'd3);
        await_result("c6", 32);
        in_valid = 1'b1;
        dividend = 32'd50;
        divisor  = 32'd6;
        for (int i = 0; i < 10; i++) begin
            tick();
            check_result("c6_hold", 32'd1000, 32'd3, 32'd333, 32'd1, 1'b0);
        end
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        chk("c6_released_valid", 64'(res_valid), 64'd0);
        chk("c6_released_ready", 64'(in_ready), 64'd1);
        tick();
        in_valid = 1'b0;
        chk("c6_next_accepted", 64'(in_ready), 64'd0);
        await_result("c6_next", 32);
        check_result("c6_next", 32'd50, 32'd6, 32'd8, 32'd2, 1'b0);
        release_result("c6_next");

        // Reset asserted at the 10th CALC edge
        send(32'd1000, 32'd3);
        for (int i = 0; i < 9; i++) tick();
        chk("c7_mid_busy", 64'(res_valid), 64'd0);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("c7_rst_res_valid", 64'(res_valid), 64'd0);
        chk("c7_rst_quotient", 64'(quotient), 64'd0);
        chk("c7_rst_remainder", 64'(remainder), 64'd0);
        chk("c7_rst_div_by_zero", 64'(div_by_zero), 64'd0);
        chk("c7_rst_in_ready", 64'(in_ready), 64'd1);
        run("c7_9_4", 32'd9, 32'd4, 32'd2, 32'd1, 1'b0, 32);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
